// File: rtl/memio_bus_arbiter.sv
// Round-robin arbiter sharing one data-memory/IO path between CPU and UART loader; ack 3 cycles after grant.
// Requesters hold req until ack (no abort); ldr_lock starves the CPU; one access in flight, 1 per 4 cycles.
module memio_bus_arbiter #(
  parameter logic [21:0] IO_HI  = 22'h3FFFFF,
  parameter int          ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ldr_lock,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_ack,
  output logic [31:0]       cpu_rdata,

  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [31:0]       ldr_wdata,
  output logic              ldr_ack,
  output logic [31:0]       ldr_rdata,

  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata,

  output logic              io_read,
  output logic              io_write,
  output logic [9:0]        io_addr,
  output logic [15:0]       io_wdata,
  input  logic [15:0]       io_rdata,

  output logic              busy
);

  localparam int HI_LSB = ADDR_W - 22;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
  typedef enum logic {G_CPU, G_LDR} grant_t;

  state_t            state, state_nxt;
  grant_t            last_grant, cur;
  logic              cpu_elig;
  logic              take_cpu, take_ldr, take;
  logic              sel_we, sel_io;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic              acc_we, acc_io;
  logic [31:0]       data_q;
  logic [31:0]       rd_val;

  assign cpu_elig = cpu_req && !ldr_lock;
  assign take     = take_cpu || take_ldr;
  assign busy     = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    take_cpu  = 1'b0;
    take_ldr  = 1'b0;
    case (state)
      S_IDLE: begin
        // On a tie the requester that did not win last time goes first.
        if (ldr_req && (!cpu_elig || last_grant == G_CPU)) take_ldr = 1'b1;
        else if (cpu_elig)                                 take_cpu = 1'b1;
        if (take_cpu || take_ldr) state_nxt = S_ISSUE;
      end
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign sel_we    = take_ldr ? ldr_we    : cpu_we;
  assign sel_addr  = take_ldr ? ldr_addr  : cpu_addr;
  assign sel_wdata = take_ldr ? ldr_wdata : cpu_wdata;
  assign sel_io    = (sel_addr[ADDR_W-1:HI_LSB] == IO_HI);

  // BRAM data arrives during WAIT, so it bypasses data_q on its way to rdata.
  assign rd_val = acc_io ? data_q : mem_rdata;

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= G_LDR;
      cur        <= G_CPU;
      acc_we     <= 1'b0;
      acc_io     <= 1'b0;
      data_q     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      io_read    <= 1'b0;
      io_write   <= 1'b0;
      io_addr    <= '0;
      io_wdata   <= '0;
      cpu_ack    <= 1'b0;
      ldr_ack    <= 1'b0;
      cpu_rdata  <= '0;
      ldr_rdata  <= '0;
    end else begin
      mem_we   <= 1'b0;
      io_read  <= 1'b0;
      io_write <= 1'b0;
      cpu_ack  <= 1'b0;
      ldr_ack  <= 1'b0;
      case (state)
        S_IDLE: if (take) begin
          cur        <= take_ldr ? G_LDR : G_CPU;
          last_grant <= take_ldr ? G_LDR : G_CPU;
          acc_we     <= sel_we;
          acc_io     <= sel_io;
          if (sel_io) begin
            io_addr  <= sel_addr[9:0];
            io_wdata <= sel_wdata[15:0];
            io_read  <= !sel_we;
            io_write <= sel_we;
          end else begin
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            mem_we    <= sel_we;
          end
        end
        S_ISSUE: if (acc_io && !acc_we) data_q <= {16'b0, io_rdata};
        S_WAIT: begin
          if (!acc_io && !acc_we) data_q <= mem_rdata;
          cpu_ack <= (cur == G_CPU);
          ldr_ack <= (cur == G_LDR);
          if (!acc_we) begin
            if (cur == G_CPU) cpu_rdata <= rd_val;
            else              ldr_rdata <= rd_val;
          end
        end
        default: ;
      endcase
    end
  end

  a_strobe_onehot: assert property (@(posedge clock) disable iff (reset)
    $onehot0({mem_we, io_read, io_write}));
  a_strobe_issue: assert property (@(posedge clock) disable iff (reset)
    (mem_we || io_read || io_write) |-> (state == S_ISSUE));

endmodule

// File: tb/tb_memio_bus_arbiter.sv
// Scoreboard bench for memio_bus_arbiter: expected acks queued at request time, popped on each ack.
module tb_memio_bus_arbiter;

  logic        clock, reset, ldr_lock;
  logic        cpu_req, cpu_we, cpu_ack;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        ldr_req, ldr_we, ldr_ack;
  logic [31:0] ldr_addr, ldr_wdata, ldr_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, io_read, io_write, busy;
  logic [9:0]  io_addr;
  logic [15:0] io_wdata, io_rdata, io_val;

  typedef struct packed {
    logic        is_ldr;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks, failures;
  int   cpu_ack_cnt, mem_we_cnt, io_read_cnt;
  logic [31:0] bram [0:255];
  logic        tb_wr;
  logic [7:0]  tb_wa;
  logic [31:0] tb_wd;
  logic [31:0] s_mem_addr, s_mem_wdata;
  logic [9:0]  s_io_addr;
  logic        s_mem_we, s_io_read, s_busy;

  memio_bus_arbiter dut (
    .clock(clock), .reset(reset), .ldr_lock(ldr_lock),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .io_read(io_read), .io_write(io_write), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_rdata(io_rdata), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous BRAM model plus a bench-side preload port.
  always @(posedge clock) begin
    if (tb_wr)       bram[tb_wa] <= tb_wd;
    else if (mem_we) bram[mem_addr[9:2]] <= mem_wdata;
    mem_rdata <= bram[mem_addr[9:2]];
  end
  assign io_rdata = io_val;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (cpu_ack) cpu_ack_cnt++;
    if (mem_we)  mem_we_cnt++;
    if (io_read) io_read_cnt++;
    if (cpu_ack || ldr_ack) begin
      if (exp_q.size() == 0) begin
        check("unexp_ack", {30'b0, cpu_ack, ldr_ack}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("ack_who", {30'b0, cpu_ack, ldr_ack}, e.is_ldr ? 32'd1 : 32'd2);
        check("rdata", e.is_ldr ? ldr_rdata : cpu_rdata, e.rdata);
      end
    end
  end

  task automatic push(input logic is_ldr, input logic [31:0] rd);
    exp_t x;
    x.is_ldr = is_ldr;
    x.rdata  = rd;
    exp_q.push_back(x);
  endtask

  task automatic drive_cpu(input logic we, input logic [31:0] a, input logic [31:0] d);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic drive_ldr(input logic we, input logic [31:0] a, input logic [31:0] d);
    ldr_req = 1'b1; ldr_we = we; ldr_addr = a; ldr_wdata = d;
  endtask

  // Counts negedges to the next ack, snapshots the first cycle, then drops requests and idles one cycle.
  task automatic wait_ack(input string tag, input int exp_lat);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
      if (n == 1) begin
        s_mem_addr = mem_addr; s_mem_wdata = mem_wdata; s_mem_we = mem_we;
        s_io_addr = io_addr; s_io_read = io_read; s_busy = busy;
      end
    end while (!(cpu_ack || ldr_ack) && n < 20);
    cpu_req = 1'b0;
    ldr_req = 1'b0;
    check(tag, n, exp_lat);
    @(negedge clock);
  endtask

  initial begin
    int mw0, ir0, ca0, nl, seen, prev;
    checks = 0; failures = 0;
    cpu_ack_cnt = 0; mem_we_cnt = 0; io_read_cnt = 0;
    reset = 1'b1; ldr_lock = 1'b0; io_val = 16'h0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    ldr_req = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0;
    tb_wr = 1'b1; tb_wa = 8'd4; tb_wd = 32'hDEADBEEF;
    @(negedge clock);
    tb_wr = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_flags", {26'b0, busy, cpu_ack, ldr_ack, mem_we, io_read, io_write}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_cpu_rdata", cpu_rdata, 32'd0);
    check("rst_io", {6'b0, io_addr, io_wdata}, 32'd0);
    reset = 1'b0;

    // 1: CPU memory read
    drive_cpu(1'b0, 32'h0000_0010, 32'h0);
    push(1'b0, 32'hDEADBEEF);
    wait_ack("t1_lat", 3);
    check("t1_mem_addr", s_mem_addr, 32'h10);
    check("t1_busy", {31'b0, s_busy}, 32'd1);
    check("t1_no_we", {31'b0, s_mem_we}, 32'd0);

    // 2: CPU IO read, zero-extended
    io_val = 16'hA5A5;
    ir0 = io_read_cnt;
    drive_cpu(1'b0, 32'hFFFF_FC70, 32'h0);
    push(1'b0, 32'h0000A5A5);
    wait_ack("t2_lat", 3);
    check("t2_io_read", {31'b0, s_io_read}, 32'd1);
    check("t2_io_addr", {22'b0, s_io_addr}, 32'h070);
    check("t2_io_read_cnt", io_read_cnt - ir0, 32'd1);

    // 5: loader memory write leaves ldr_rdata alone
    mw0 = mem_we_cnt;
    drive_ldr(1'b1, 32'h0000_0004, 32'h12345678);
    push(1'b1, 32'h0);
    wait_ack("t5_lat", 3);
    check("t5_we", {31'b0, s_mem_we}, 32'd1);
    check("t5_wdata", s_mem_wdata, 32'h12345678);
    check("t5_we_cnt", mem_we_cnt - mw0, 32'd1);
    check("t5_bram", bram[1], 32'h12345678);

    // 3: simultaneous requests after reset alternate CPU, LDR, CPU
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    drive_cpu(1'b0, 32'h10, 32'h0);
    drive_ldr(1'b0, 32'h4, 32'h0);
    push(1'b0, 32'hDEADBEEF);
    push(1'b1, 32'h12345678);
    push(1'b0, 32'hDEADBEEF);
    seen = 0; prev = 0;
    for (int c = 1; c <= 40 && seen < 3; c++) begin
      @(negedge clock);
      if (cpu_ack || ldr_ack) begin
        seen++;
        if (seen == 1) check("t3_first_lat", c, 3);
        else           check("t3_gap", c - prev, 4);
        prev = c;
        if (seen == 3) begin cpu_req = 1'b0; ldr_req = 1'b0; end
      end
    end
    check("t3_acks", seen, 3);
    @(negedge clock);

    // 4: lock starves the CPU until released
    ca0 = cpu_ack_cnt; mw0 = mem_we_cnt; nl = 0;
    ldr_lock = 1'b1;
    drive_cpu(1'b0, 32'h10, 32'h0);
    drive_ldr(1'b1, 32'h8, 32'hCAFE0001);
    push(1'b1, 32'h12345678);
    push(1'b1, 32'h12345678);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clock);
      if (ldr_ack) begin
        nl++;
        if (nl == 2) begin
          ldr_req = 1'b0; ldr_lock = 1'b0;
          push(1'b0, 32'hDEADBEEF);
          break;
        end
      end
    end
    check("t4_ldr_acks", nl, 2);
    check("t4_cpu_starved", cpu_ack_cnt - ca0, 32'd0);
    check("t4_we_cnt", mem_we_cnt - mw0, 32'd2);
    wait_ack("t4_cpu_lat", 4);

    // 6: reset during WAIT aborts; held request regranted afterwards
    drive_cpu(1'b0, 32'h10, 32'h0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("t6_flags", {28'b0, busy, cpu_ack, mem_we, io_read}, 32'd0);
    check("t6_rdata_rst", cpu_rdata, 32'd0);
    reset = 1'b0;
    push(1'b0, 32'hDEADBEEF);
    wait_ack("t6_regrant_lat", 3);

    repeat (4) @(negedge clock);
    check("sb_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1);
  end

endmodule
